// File: rtl/ring_rr_arbiter_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
// State encoding and one-hot to index conversion.
package ring_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int MAX_N = 32;

  function automatic int unsigned onehot_to_idx(
    input logic [MAX_N-1:0] v
  );
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_rr_pick.sv
// Round-robin pick: first set request at or above the
// one-hot priority position, wrapping from N-1 to 0.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] prio,
  output logic [N-1:0] win
);

  localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] cand;
  logic [2*N-1:0] low;

  // Doubled vector turns the wrap-around scan into a linear
  // lowest-set-bit search above the priority position.
  assign dbl  = {req, req};
  assign mask = ~({{N{1'b0}}, prio} - ONE);
  assign cand = dbl & mask;
  assign low  = cand & (~cand + ONE);
  assign win  = low[N-1:0] | low[2*N-1:N];

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with rotating one-hot priority ring
// and a hold timer that forces handoff under contention.
module ring_rr_arbiter
  import ring_rr_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int IW       = $clog2(N),
  localparam int HW      = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          start_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id,
  output logic          preempt,
  output logic [HW-1:0] hold_cnt
);

  localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);
  localparam logic [N-1:0]  PRIO_RST = {{(N-1){1'b0}}, 1'b1};

  state_t        state_q;
  state_t        state_d;
  logic [N-1:0]  prio_q;
  logic [N-1:0]  prio_d;
  logic [N-1:0]  grant_d;
  logic [HW-1:0] hold_d;
  logic          pre_d;
  logic [IW-1:0] id_d;

  logic [N-1:0]  rot;
  logic [N-1:0]  cand;
  logic [N-1:0]  pick_prio;
  logic [N-1:0]  win;

  assign rot  = {grant[N-2:0], grant[N-1]};
  assign cand = req & ~grant;

  // While owning, the next pick already uses the rotated
  // pointer so a handoff needs no idle bubble.
  assign pick_prio = (state_q == OWN) ? rot : prio_q;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req  (cand),
    .prio (pick_prio),
    .win  (win)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant;
    hold_d  = hold_cnt;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = win;
          hold_d  = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!(|(req & grant))) begin
          prio_d  = rot;
          grant_d = win;
          hold_d  = '0;
          if (!(|cand)) state_d = IDLE;
        end else if (hold_cnt == HOLD_TOP && |cand) begin
          prio_d  = rot;
          grant_d = win;
          hold_d  = '0;
          pre_d   = 1'b1;
        end else if (hold_cnt != HOLD_TOP) begin
          hold_d = hold_cnt + HW'(1);
        end
      end
    endcase
  end

  assign id_d = IW'(onehot_to_idx(MAX_N'(grant_d)));

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      state_q     <= IDLE;
      prio_q      <= PRIO_RST;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      preempt     <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      grant       <= grant_d;
      grant_valid <= |grant_d;
      grant_id    <= id_d;
      preempt     <= pre_d;
      hold_cnt    <= hold_d;
    end
  end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter: directed vector table, corner
// sequences, and random traffic against a behavioural model.
module tb_ring_rr_arbiter;

  logic       clk;
  logic       start_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       preempt;
  logic [2:0] hold_cnt;

  int errors;
  int checks;

  ring_rr_arbiter #(
    .N        (4),
    .MAX_HOLD (4)
  ) dut (
    .clk         (clk),
    .start_n     (start_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .preempt     (preempt),
    .hold_cnt    (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic       pre;
    logic [2:0] hold;
  } vec_t;

  vec_t tv[22];

  int m_owner;
  int m_ptr;
  int m_hold;
  int m_pre;
  int wait_cnt[4];

  task automatic check_out(
    input string      name,
    input logic [3:0] eg,
    input logic       ep,
    input logic [2:0] eh
  );
    int eid;
    logic ev;
    eid = 0;
    for (int i = 0; i < 4; i++) if (eg[i]) eid = i;
    ev = (eg != 4'b0);
    checks++;
    if (grant !== eg || grant_id !== 2'(eid) ||
        grant_valid !== ev || preempt !== ep ||
        hold_cnt !== eh) begin
      errors++;
      $display("FAIL %s: grant=%b id=%0d valid=%b pre=%b hold=%0d want grant=%b id=%0d valid=%b pre=%b hold=%0d",
               name, grant, grant_id, grant_valid, preempt,
               hold_cnt, eg, eid, ev, ep, eh);
    end
  endtask

  task automatic cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start_n = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    start_n = 1'b1;
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_grant();
    if (m_owner < 0) return 4'b0000;
    return 4'(1 << m_owner);
  endfunction

  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    m_pre = 0;
    if (m_owner < 0) begin
      if (r != 4'b0) begin
        m_owner = pick(r, m_ptr);
        m_hold = 0;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % 4;
        m_owner = pick(others, m_ptr);
        m_hold = 0;
      end else if (m_hold == 3 && others != 4'b0) begin
        m_ptr = (m_owner + 1) % 4;
        m_owner = pick(others, m_ptr);
        m_hold = 0;
        m_pre = 1;
      end else if (m_hold < 3) begin
        m_hold++;
      end
    end
  endtask

  initial begin
    logic [3:0] cur;
    logic [3:0] nr;
    int worst;
    errors = 0;
    checks = 0;

    tv[0]  = '{4'b0011, 4'b0001, 1'b0, 3'd0};
    tv[1]  = '{4'b0011, 4'b0001, 1'b0, 3'd1};
    tv[2]  = '{4'b0011, 4'b0001, 1'b0, 3'd2};
    tv[3]  = '{4'b0011, 4'b0001, 1'b0, 3'd3};
    tv[4]  = '{4'b0011, 4'b0010, 1'b1, 3'd0};
    tv[5]  = '{4'b0011, 4'b0010, 1'b0, 3'd1};
    tv[6]  = '{4'b0011, 4'b0010, 1'b0, 3'd2};
    tv[7]  = '{4'b0011, 4'b0010, 1'b0, 3'd3};
    tv[8]  = '{4'b0011, 4'b0001, 1'b1, 3'd0};
    tv[9]  = '{4'b0001, 4'b0001, 1'b0, 3'd1};
    tv[10] = '{4'b0001, 4'b0001, 1'b0, 3'd2};
    tv[11] = '{4'b0001, 4'b0001, 1'b0, 3'd3};
    tv[12] = '{4'b1000, 4'b1000, 1'b0, 3'd0};
    tv[13] = '{4'b1000, 4'b1000, 1'b0, 3'd1};
    tv[14] = '{4'b0000, 4'b0000, 1'b0, 3'd0};
    tv[15] = '{4'b0000, 4'b0000, 1'b0, 3'd0};
    tv[16] = '{4'b1010, 4'b0010, 1'b0, 3'd0};
    tv[17] = '{4'b1010, 4'b0010, 1'b0, 3'd1};
    tv[18] = '{4'b1000, 4'b1000, 1'b0, 3'd0};
    tv[19] = '{4'b1010, 4'b1000, 1'b0, 3'd1};
    tv[20] = '{4'b0010, 4'b0010, 1'b0, 3'd0};
    tv[21] = '{4'b0000, 4'b0000, 1'b0, 3'd0};

    // Reset held with every requester active.
    start_n = 1'b0;
    req = 4'b1111;
    #12;
    check_out("reset", 4'b0000, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    check_out("reset_hold", 4'b0000, 1'b0, 3'd0);
    @(negedge clk);
    start_n = 1'b1;
    cycle(4'b1111);
    check_out("first_grant", 4'b0001, 1'b0, 3'd0);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      cycle(tv[i].req);
      check_out($sformatf("vec%0d", i),
                tv[i].grant, tv[i].pre, tv[i].hold);
    end

    // Sole requester never preempted, hold saturates.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      cycle(4'b0100);
      check_out($sformatf("sole%0d", k), 4'b0100, 1'b0,
                3'(k > 3 ? 3 : k));
    end

    // Asynchronous reset between edges while granted.
    #2;
    start_n = 1'b0;
    #1;
    check_out("async_rst", 4'b0000, 1'b0, 3'd0);
    req = 4'b0110;
    @(negedge clk);
    start_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("after_async", 4'b0010, 1'b0, 3'd0);

    // Random traffic against the model.
    do_reset();
    m_owner = -1;
    m_ptr = 0;
    m_hold = 0;
    m_pre = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    cur = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      nr = cur;
      for (int i = 0; i < 4; i++) begin
        if (m_owner == i) begin
          if ($urandom_range(0, 3) == 0) nr[i] = 1'b0;
        end else if (!nr[i]) begin
          if ($urandom_range(0, 2) == 0) nr[i] = 1'b1;
        end else if ($urandom_range(0, 15) == 0) begin
          nr[i] = 1'b0;
        end
      end
      cycle(nr);
      model_step(nr);
      check_out($sformatf("rand%0d", c), m_grant(),
                1'(m_pre), 3'(m_hold));
      worst = 0;
      for (int i = 0; i < 4; i++) begin
        if (nr[i] && grant[i] !== 1'b1) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > worst) worst = wait_cnt[i];
      end
      checks++;
      if (worst > 13) begin
        errors++;
        $display("FAIL wait%0d: waited=%0d limit=13", c, worst);
      end
      cur = nr;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
